// File: rtl/approx_cmp_pkg.sv
// Shared widths and result encoding for the 8-bit approximate magnitude comparator.
// Optional macro APPROX_CMP_EXACT_LSB_EN (see approx_cmp_lsb2) makes the whole block exact.
package approx_cmp_pkg;

    localparam int DATA_W   = 8;
    localparam int APPROX_W = 2;
    localparam int HIGH_W   = 6;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_res_e;

    // One-hot flag vector ordered {eq, gt, lt}.
    function automatic logic [2:0] res_to_flags(input cmp_res_e r);
        logic [2:0] f;
        f = 3'b100;
        case (r)
            CMP_GT:  f = 3'b010;
            CMP_LT:  f = 3'b001;
            default: f = 3'b100;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/approx_cmp_lsb2.sv
// Combinational 2-bit low-field comparator producing gtL/ltL.
// Default: reduced logic that reports 11 vs 10 (and 10 vs 11) as equal; APPROX_CMP_EXACT_LSB_EN selects an exact compare.
module approx_cmp_lsb2
    import approx_cmp_pkg::*;
(
    input  logic [APPROX_W-1:0] i_a,
    input  logic [APPROX_W-1:0] i_b,
    output logic                o_gt,
    output logic                o_lt
);

`ifdef APPROX_CMP_EXACT_LSB_EN
    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);
`else
    // Terms on bit 0 are only considered when the other side's bit 1 is clear.
    assign o_gt = (i_a[1] & ~i_b[1]) | (i_a[0] & ~i_b[0] & ~i_b[1]);
    assign o_lt = (~i_a[1] & i_b[1]) | (~i_a[0] & i_b[0] & ~i_a[1]);
`endif

endmodule

// File: rtl/approx_comparator_8bit.sv
// Registered 8-bit unsigned comparator: exact compare on bits [7:2], approximate (or exact with
// APPROX_CMP_EXACT_LSB_EN) compare on bits [1:0]; one-cycle latency, no backpressure.
module approx_comparator_8bit
    import approx_cmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    output logic              AeqB,
    output logic              AgtB,
    output logic              AltB
);

    // Handshake: a/b are taken on every rising edge where in_valid=1; the result appears with
    // out_valid=1 after that edge. When in_valid=0 out_valid drops and the flags keep their value.

    logic     w_hi_gt;
    logic     w_hi_lt;
    logic     w_lo_gt;
    logic     w_lo_lt;
    cmp_res_e w_res;
    logic [2:0] w_flags;

    logic r_valid;
    logic r_eq;
    logic r_gt;
    logic r_lt;

    assign w_hi_gt = (a[DATA_W-1:APPROX_W] > b[DATA_W-1:APPROX_W]);
    assign w_hi_lt = (a[DATA_W-1:APPROX_W] < b[DATA_W-1:APPROX_W]);

    approx_cmp_lsb2 u_lsb (
        .i_a  (a[APPROX_W-1:0]),
        .i_b  (b[APPROX_W-1:0]),
        .o_gt (w_lo_gt),
        .o_lt (w_lo_lt)
    );

    // High field dominates; low field only decides on a high-field tie.
    always_comb begin
        w_res = CMP_EQ;
        if (w_hi_gt) begin
            w_res = CMP_GT;
        end else if (w_hi_lt) begin
            w_res = CMP_LT;
        end else if (w_lo_gt) begin
            w_res = CMP_GT;
        end else if (w_lo_lt) begin
            w_res = CMP_LT;
        end
    end

    assign w_flags = res_to_flags(w_res);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_eq <= w_flags[2];
                r_gt <= w_flags[1];
                r_lt <= w_flags[0];
            end
        end
    end

    assign out_valid = r_valid;
    assign AeqB      = r_eq;
    assign AgtB      = r_gt;
    assign AltB      = r_lt;

endmodule

// File: tb/tb_approx_comparator_8bit.sv
// Self-checking bench for approx_comparator_8bit: directed cases, streaming, reset and an
// exhaustive sweep against an arithmetic reference model (honours APPROX_CMP_EXACT_LSB_EN).
module tb_approx_comparator_8bit;

`ifdef APPROX_CMP_EXACT_LSB_EN
  localparam bit APPROX = 1'b0;
`else
  localparam bit APPROX = 1'b1;
`endif

  // clock / reset
  logic clk;
  logic rst_n;
  logic in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic out_valid;
  logic AeqB;
  logic AgtB;
  logic AltB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  approx_comparator_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .AeqB      (AeqB),
    .AgtB      (AgtB),
    .AltB      (AltB)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail = 0;
  int n_err_expected = 0;
  int n_err_seen = 0;
  logic [2:0] last_flags = 3'b000;
  // entry = {sweep, exact_flags[2:0], out_valid, eq, gt, lt}
  logic [7:0] exp_q[$];
  logic [7:0] e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, expv, $time);
    end
  endtask

  // reference model: 0 = eq, 1 = gt, 2 = lt
  function automatic int ref_cmp(input int av, input int bv, input bit approx);
    int ha, hb, la, lb;
    ha = av / 4;
    hb = bv / 4;
    la = av % 4;
    lb = bv % 4;
    if (ha > hb) return 1;
    if (ha < hb) return 2;
    if (approx && la >= 2 && lb >= 2) return 0;
    if (la > lb) return 1;
    if (la < lb) return 2;
    return 0;
  endfunction

  function automatic logic [2:0] code_flags(input int c);
    if (c == 1) return 3'b010;
    if (c == 2) return 3'b001;
    return 3'b100;
  endfunction

  // driver tasks
  task automatic apply(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic sweep);
    logic [2:0] f;
    logic [2:0] fx;
    in_valid = v;
    a = av;
    b = bv;
    fx = last_flags;
    if (v) begin
      f = code_flags(ref_cmp(int'(av), int'(bv), APPROX));
      fx = code_flags(ref_cmp(int'(av), int'(bv), 1'b0));
      last_flags = f;
      if (sweep && (f != fx)) n_err_expected++;
    end
    exp_q.push_back({sweep, fx, v, last_flags});
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic sweep);
    @(negedge clk);
    apply(v, av, bv, sweep);
  endtask

  task automatic check_cleared(input string tag);
    check_val(tag, {28'd0, out_valid, AeqB, AgtB, AltB}, 32'd0);
  endtask

  // monitor: each queued entry is due 1 time unit after the following rising edge
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("flags", {28'd0, out_valid, AeqB, AgtB, AltB}, {28'd0, e[3:0]});
      if (out_valid) check_val("onehot", {31'd0, $onehot({AeqB, AgtB, AltB})}, 32'd1);
      if (e[7] && ({AeqB, AgtB, AltB} != e[6:4])) n_err_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    #1;
    check_cleared("reset_t0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_cleared("reset_hold");
    end

    // release with the GT sample already presented
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 8'hFF, 8'h00, 1'b0);
    #1;
    check_cleared("release_pre_edge");

    // directed decisions
    drive(1'b1, 8'hF0, 8'h0F, 1'b0);
    drive(1'b1, 8'h55, 8'hAA, 1'b0);
    drive(1'b1, 8'hFF, 8'hF0, 1'b0);
    drive(1'b1, 8'h80, 8'h7F, 1'b0);
    drive(1'b1, 8'hAA, 8'hAA, 1'b0);
    drive(1'b1, 8'hCC, 8'hCC, 1'b0);
    drive(1'b1, 8'h01, 8'h02, 1'b0);
    drive(1'b1, 8'h02, 8'h01, 1'b0);
    drive(1'b1, 8'h03, 8'h02, 1'b0);
    drive(1'b1, 8'h02, 8'h03, 1'b0);

    // gap: out_valid drops, flags hold
    drive(1'b1, 8'hAA, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 8'hFF, 1'b0);
    drive(1'b0, 8'h11, 8'h22, 1'b0);

    // back-to-back alternating GT/LT
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hF0, 8'h0F, 1'b0);
      drive(1'b1, 8'h0F, 8'hF0, 1'b0);
    end

    // random stream with random gaps
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

    // mid-stream reset with a sample in flight
    drive(1'b1, 8'h40, 8'h10, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_flags = 3'b000;
    #1;
    check_cleared("midreset_immediate");
    @(posedge clk);
    #1;
    check_cleared("midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 8'h12, 8'h34, 1'b0);
    drive(1'b1, 8'h10, 8'h40, 1'b0);

    // exhaustive sweep, one pair per cycle
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] p;
      p = 16'(i);
      drive(1'b1, p[15:8], p[7:0], 1'b1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    check_val("sweep_err_count", 32'(n_err_seen), 32'(n_err_expected));
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
